// File: rtl/dbus_sram_responder_pkg.sv
// Shared definitions for the data-bus responder slice (package common).
// Contents:
//   msize_t      - access size, encoded as log2(bytes)
//   dbus_req_t   - request from the memory stage: valid, addr, size, strobe, data
//   dbus_resp_t  - response back to the memory stage: addr_ok, data_ok, data
//   resp_state_t - responder FSM states
//   DBUS_POISON  - data returned for rejected (misaligned) requests
//   size_mask()  - low-address-bit mask that must be zero for an aligned access
package common;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    localparam logic [63:0] DBUS_POISON = 64'hdead_beef_dead_beef;

    function automatic logic [63:0] size_mask(input msize_t size);
        return (64'd1 << size) - 64'd1;
    endfunction

endpackage

// File: rtl/dbus_sram_responder_array.sv
// Word-wide SRAM for the data-bus responder.
// Ports:
//   clk   - clock, write on posedge
//   we    - write enable
//   widx  - word index for writes
//   wstrb - byte-lane write strobes
//   wdata - write data
//   ridx  - word index for reads
//   rdata - asynchronous read data
// Storage is split into one byte-wide array per lane so each lane has a
// single writer; contents are never reset.
module dbus_sram_array #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] widx,
    input  logic [7:0]    wstrb,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] ridx,
    output logic [63:0]   rdata
);

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        logic [7:0] lane_mem [MEM_WORDS];

        always_ff @(posedge clk) begin
            if (we && wstrb[gi]) begin
                lane_mem[widx] <= wdata[8*gi +: 8];
            end
        end

        assign rdata[8*gi +: 8] = lane_mem[ridx];
    end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder: memory-side end of the dbus handshake.
// Accepts a request in IDLE (addr_ok combinational), waits LATENCY cycles,
// then gives a one-cycle data_ok with read data (or 0 for writes).
// Ports:
//   clk   - clock
//   rst   - asynchronous active-low reset
//   dreq  - request (valid, addr, size, strobe, data)
//   dresp - response (addr_ok, data_ok, data)
//   err   - sticky misalignment flag
// Optional feature: define DBUS_RESP_MISALIGN_CHECK_EN to reject misaligned
// requests with poison data and set err; otherwise err is tied 0 and
// misaligned accesses act on the containing 8-byte word.
module dbus_sram_responder
    import common::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 2,      // 1..15
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       err
);

    localparam int          AW       = $clog2(MEM_WORDS);
    localparam logic [63:0] SPAN     = 64'(MEM_WORDS) * 64'd8;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    resp_state_t state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [63:0] addr_reg;
    logic [7:0]  strobe_reg;
    logic [63:0] data_reg;

    logic        accept;
    logic [63:0] offset;
    logic        in_range;
    logic        bad_req;
    logic        mem_we;
    logic [63:0] mem_rdata;
    logic [63:0] resp_data;

    assign accept   = (state_reg == IDLE) && dreq.valid;
    assign offset   = addr_reg - BASE_ADDR;   // wraps, so addr < BASE is out of range too
    assign in_range = offset < SPAN;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            addr_reg   <= '0;
            strobe_reg <= '0;
            data_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg   <= dreq.addr;
                strobe_reg <= dreq.strobe;
                data_reg   <= dreq.data;
            end
        end
    end

`ifdef DBUS_RESP_MISALIGN_CHECK_EN
    msize_t size_reg;
    logic   err_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            size_reg <= MSIZE1;
            err_reg  <= 1'b0;
        end else begin
            if (accept) begin
                size_reg <= dreq.size;
            end
            if (state_reg == RESP && bad_req) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bad_req = |(addr_reg & size_mask(size_reg));
    assign err     = err_reg;
`else
    wire unused_size = ^dreq.size;

    assign bad_req = 1'b0;
    assign err     = 1'b0;
`endif

    // Every latency, including 1, passes through WAIT so data_ok always
    // lands LATENCY+1 cycles after addr_ok.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mem_we     = 1'b0;
        resp_data  = '0;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next   = CNT_INIT;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
                if (bad_req) begin
                    resp_data = DBUS_POISON;
                end else if (strobe_reg != 8'd0) begin
                    mem_we = in_range;
                end else if (in_range) begin
                    resp_data = mem_rdata;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // rst gates addr_ok so an asserted reset never acknowledges a request.
    assign dresp.addr_ok = rst && accept;
    assign dresp.data_ok = (state_reg == RESP);
    assign dresp.data    = resp_data;

    dbus_sram_array #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .widx  (offset[AW+2:3]),
        .wstrb (strobe_reg),
        .wdata (data_reg),
        .ridx  (offset[AW+2:3]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dbus_sram_responder.sv
module tb_dbus_sram_responder;
    import common::*;

    localparam int          LAT   = 2;
    localparam int          WORDS = 1024;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [63:0] SPANB = 64'(WORDS) * 64'd8;

    logic       clk = 1'b0;
    logic       rst;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       err;

    int checks   = 0;
    int failures = 0;

    // Reference memory: a plain word array indexed by byte offset / 8.
    logic [63:0] mem_m [WORDS];

    always #5 clk = ~clk;

    dbus_sram_responder #(
        .MEM_WORDS (WORDS),
        .LATENCY   (LAT),
        .BASE_ADDR (BASE)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .dreq  (dreq),
        .dresp (dresp),
        .err   (err)
    );

    function automatic void model_write(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
        logic [63:0] off;
        int idx;
        off = a - BASE;
        if (off < SPANB) begin
            idx = int'(off / 64'd8);
            for (int i = 0; i < 8; i++) begin
                if (s[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
            end
        end
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] a);
        logic [63:0] off;
        off = a - BASE;
        if (off < SPANB) return mem_m[int'(off / 64'd8)];
        return 64'd0;
    endfunction

    // One full handshake; entered and left at posedge+1 of an IDLE cycle.
    task automatic do_txn(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] s,
                          input logic [63:0] d, input string tag, output logic [63:0] rd);
        int k;
        dreq.valid  = 1'b1;
        dreq.addr   = a;
        dreq.size   = msize_t'(sz);
        dreq.strobe = s;
        dreq.data   = d;
        #1;
        checks++;
        if (dresp.addr_ok !== 1'b1) begin
            failures++;
            $display("FAIL %s addr_ok got=%b exp=1", tag, dresp.addr_ok);
        end
        k  = 0;
        rd = '0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (dresp.data_ok === 1'b1) begin
                k = c;
                break;
            end
        end
        checks++;
        if (k != LAT + 1) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=%0d", tag, k, LAT + 1);
        end
        rd = dresp.data;
        dreq.valid = 1'b0;
        @(posedge clk); #1;
        $display("txn %s addr=%h size=%0d strobe=%h wdata=%h rdata=%h lat=%0d", tag, a, sz, s, d, rd, k);
    endtask

    task automatic wr(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] s,
                      input logic [63:0] d, input string tag);
        logic [63:0] rd;
        do_txn(a, sz, s, d, tag, rd);
        checks++;
        if (rd !== 64'd0) begin
            failures++;
            $display("FAIL %s write_data got=%h exp=0", tag, rd);
        end
        model_write(a, s, d);
    endtask

    task automatic rd_expect(input logic [63:0] a, input logic [63:0] exp, input string tag);
        logic [63:0] rd;
        do_txn(a, 3'd3, 8'h00, 64'd0, tag, rd);
        checks++;
        if (rd !== exp) begin
            failures++;
            $display("FAIL %s read_data got=%h exp=%h", tag, rd, exp);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        dreq.valid  = 1'b1;
        dreq.addr   = BASE;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'h1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({dresp.addr_ok, dresp.data_ok, err} !== 3'b000 || dresp.data !== 64'd0) begin
                failures++;
                $display("FAIL reset cyc%0d got addr_ok=%b data_ok=%b err=%b data=%h exp all 0",
                         i, dresp.addr_ok, dresp.data_ok, err, dresp.data);
            end
            $display("reset cycle %0d addr_ok=%b data_ok=%b data=%h err=%b",
                     i, dresp.addr_ok, dresp.data_ok, dresp.data, err);
        end
        dreq.valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        wr(BASE + 64'h10, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, "wr_full");
        rd_expect(BASE + 64'h10, 64'h1122_3344_5566_7788, "rd_full");
    endtask

    task automatic test_strobe();
        wr(BASE + 64'h10, 3'd3, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, "wr_strobe");
        rd_expect(BASE + 64'h10, 64'h1122_3344_BBBB_BBBB, "rd_strobe");
    endtask

    task automatic test_out_of_range();
        wr(BASE, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, "wr_word0");
        rd_expect(64'h7FFF_FFF8, 64'd0, "rd_below");
        wr(BASE + SPANB, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, "wr_above");
        rd_expect(BASE, 64'h0123_4567_89AB_CDEF, "rd_word0_kept");
        rd_expect(BASE + SPANB, 64'd0, "rd_above");
    endtask

    task automatic test_midflight_valid();
        int k;
        wr(BASE + 64'h20, 3'd3, 8'hFF, 64'h5555_5555_5555_5555, "wr_w4");
        dreq.valid  = 1'b1;
        dreq.addr   = BASE + 64'h18;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'hCAFE_F00D_1234_5678;
        #1;
        checks++;
        if (dresp.addr_ok !== 1'b1) begin
            failures++;
            $display("FAIL drop_valid addr_ok got=%b exp=1", dresp.addr_ok);
        end
        @(posedge clk); #1;
        // Request changes and disappears while the responder is waiting.
        dreq.valid = 1'b0;
        dreq.addr  = BASE + 64'h20;
        dreq.data  = 64'hFFFF_0000_FFFF_0000;
        k = (dresp.data_ok === 1'b1) ? 1 : 0;
        for (int c = 2; c <= 10 && k == 0; c++) begin
            @(posedge clk); #1;
            if (dresp.data_ok === 1'b1) k = c;
        end
        checks++;
        if (k != LAT + 1) begin
            failures++;
            $display("FAIL drop_valid latency got=%0d exp=%0d", k, LAT + 1);
        end
        @(posedge clk); #1;
        $display("txn drop_valid data_ok at cycle %0d", k);
        model_write(BASE + 64'h18, 8'hFF, 64'hCAFE_F00D_1234_5678);
        rd_expect(BASE + 64'h18, 64'hCAFE_F00D_1234_5678, "rd_latched");
        rd_expect(BASE + 64'h20, 64'h5555_5555_5555_5555, "rd_w4_kept");
    endtask

    task automatic test_reset_midflight();
        int seen;
        wr(BASE + 64'h28, 3'd3, 8'hFF, 64'h7777_7777_7777_7777, "wr_w5");
        dreq.valid  = 1'b1;
        dreq.addr   = BASE + 64'h28;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'h9999_9999_9999_9999;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        dreq.valid = 1'b0;
        seen = 0;
        if (dresp.data_ok === 1'b1) seen++;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (dresp.data_ok === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_midflight data_ok pulses got=%0d exp=0", seen);
        end
        $display("txn rst_midflight data_ok pulses=%0d", seen);
        rd_expect(BASE + 64'h28, 64'h7777_7777_7777_7777, "rd_w5_kept");
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        exp = model_read(BASE + 64'h10);
        dreq.valid  = 1'b1;
        dreq.addr   = BASE + 64'h10;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
        dreq.data   = 64'd0;
        #1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (dresp.addr_ok !== ((i % (LAT + 2)) == 0) ||
                dresp.data_ok !== ((i % (LAT + 2)) == LAT + 1) ||
                (dresp.data_ok === 1'b1 && dresp.data !== exp)) begin
                failures++;
                $display("FAIL b2b cyc%0d got addr_ok=%b data_ok=%b data=%h exp addr_ok=%b data_ok=%b data=%h",
                         i, dresp.addr_ok, dresp.data_ok, dresp.data,
                         (i % (LAT + 2)) == 0, (i % (LAT + 2)) == LAT + 1, exp);
            end
            $display("b2b cycle %0d addr_ok=%b data_ok=%b data=%h", i, dresp.addr_ok, dresp.data_ok, dresp.data);
            @(posedge clk); #1;
        end
        dreq.valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [63:0] a, d, rd, exp;
        logic [7:0]  s;
        logic [2:0]  sz;
        int          pick;
        for (int i = 0; i < 16; i++) begin
            wr(BASE + 64'(i * 8), 3'd3, 8'hFF, {$urandom, $urandom}, "rnd_init");
        end
        for (int n = 0; n < 40; n++) begin
            sz   = 3'($urandom_range(0, 3));
            pick = $urandom_range(0, 9);
            if (pick == 0)      a = BASE - 64'(8 * $urandom_range(1, 4));
            else if (pick == 1) a = BASE + SPANB + 64'(8 * $urandom_range(0, 4));
            else                a = BASE + 64'(8 * $urandom_range(0, 15));
            // low bits: a random multiple of the access size, so always aligned
            a = a + 64'(($urandom_range(0, 7) >> sz) << sz);
            s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            d = {$urandom, $urandom};
            exp = (s == 8'h00) ? model_read(a) : 64'd0;
            do_txn(a, sz, s, d, "rnd", rd);
            checks++;
            if (rd !== exp) begin
                failures++;
                $display("FAIL rnd%0d data got=%h exp=%h addr=%h strobe=%h", n, rd, exp, a, s);
            end
            if (s != 8'h00) model_write(a, s, d);
        end
    endtask

`ifdef DBUS_RESP_MISALIGN_CHECK_EN
    task automatic test_misalign();
        logic [63:0] rd;
        wr(BASE, 3'd3, 8'hFF, 64'h0A0B_0C0D_0E0F_1011, "wr_word0_mis");
        do_txn(BASE + 64'h2, 3'd2, 8'h0F, 64'h1234_5678_9ABC_DEF0, "mis_wr", rd);
        checks++;
        if (rd !== 64'hDEAD_BEEF_DEAD_BEEF) begin
            failures++;
            $display("FAIL misalign data got=%h exp=deadbeefdeadbeef", rd);
        end
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL misalign err got=%b exp=1", err);
        end
        rd_expect(BASE, 64'h0A0B_0C0D_0E0F_1011, "rd_word0_unchanged");
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL misalign err_sticky got=%b exp=1", err);
        end
    endtask
`else
    task automatic test_misalign();
        logic [63:0] rd;
        wr(BASE, 3'd3, 8'hFF, 64'h0A0B_0C0D_0E0F_1011, "wr_word0_mis");
        do_txn(BASE + 64'h2, 3'd2, 8'h0F, 64'h1234_5678_DDCC_BBAA, "mis_wr", rd);
        checks++;
        if (rd !== 64'd0) begin
            failures++;
            $display("FAIL misalign_off data got=%h exp=0", rd);
        end
        rd_expect(BASE, 64'h0A0B_0C0D_DDCC_BBAA, "rd_word0_aligned");
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL misalign_off err got=%b exp=0", err);
        end
    endtask
`endif

    initial begin
        rst  = 1'b0;
        dreq = '0;
        for (int i = 0; i < WORDS; i++) mem_m[i] = 64'd0;
        test_reset();
        test_write_read();
        test_strobe();
        test_out_of_range();
        test_midflight_valid();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
